// File: rtl/ctl_fetch_responder.sv
// ctl_fetch_responder
//   Control-bus responder for program-counter instruction fetches. A
//   CTL_READ_ADDR opcode in IDLE latches an address. The responder then
//   returns the 4-byte word at that address, one byte per cycle and
//   little-endian, on bus_data_out/bus_valid. pc_inhibit stalls the PC for
//   the whole transfer. A re-issue of the address that was last accepted
//   (the PC is held by pc_inhibit) is not treated as a new request.
//
//   Optional feature macro: CTL_WRITE_EN
//     Enables single-byte writes with opcode CTL_WRITE_BYTE. When the macro
//     is undefined the memory is read-only and that opcode is ignored.
//
// Ports
//   clk           in   1   clock; all state changes on posedge
//   reset         in   1   asynchronous, active-low reset
//   ctl_op_in     in   8   control opcode (held by the requester, not pulsed)
//   ctl_data_in   in   64  control payload (read address / write addr+data)
//   bus_data_out  out  8   returned instruction byte
//   bus_valid     out  1   bus_data_out carries a valid byte this cycle
//   pc_inhibit    out  1   PC stall; high for the whole 5-cycle transfer
//   busy          out  1   FSM not in IDLE
//   err           out  1   range error for the last accepted request
module ctl_fetch_responder #(
  parameter logic [7:0]  CTL_READ_ADDR  = 8'h02,
  parameter logic [7:0]  CTL_WRITE_BYTE = 8'h03,
  parameter int unsigned ADDR_W         = 17,
  parameter int unsigned MEM_BYTES      = 256,
  parameter              INIT_FILE      = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  ctl_op_in,
  input  logic [63:0] ctl_data_in,
  output logic [7:0]  bus_data_out,
  output logic        bus_valid,
  output logic        pc_inhibit,
  output logic        busy,
  output logic        err
);

  localparam int unsigned IDX_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);
  localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(MEM_BYTES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [1:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] last_addr;
  logic              last_valid;

  logic [7:0] mem [MEM_BYTES];

  logic [ADDR_W-1:0] req_addr;
  logic              rd_accept;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_byte;
  logic              wr_req;
  logic              wr_in_range;

  always_comb begin
    req_addr  = ctl_data_in[ADDR_W-1:0];
    rd_accept = (state == S_IDLE) && (ctl_op_in == CTL_READ_ADDR) &&
                (!last_valid || (req_addr != last_addr));
    // Address sum stays in ADDR_W bits. err already flags any word that
    // would run past the end of memory, so the truncated index below is
    // only used for in-range addresses.
    rd_addr   = addr_q + ADDR_W'(cnt);
    rd_byte   = err ? '0 : mem[rd_addr[IDX_W-1:0]];
  end

`ifdef CTL_WRITE_EN
  logic [ADDR_W-1:0] wr_addr;

  always_comb begin
    wr_addr     = ctl_data_in[ADDR_W+7:8];
    wr_req      = (state == S_IDLE) && (ctl_op_in == CTL_WRITE_BYTE);
    wr_in_range = (wr_addr <= LAST_BYTE);
  end

  // Memory is not reset. A held write opcode rewrites the same byte on
  // every edge, which is harmless.
  always_ff @(posedge clk) begin
    if (wr_req && wr_in_range) begin
      mem[wr_addr[IDX_W-1:0]] <= ctl_data_in[7:0];
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ctl_data_in[63:ADDR_W+8], rd_addr[ADDR_W-1:IDX_W],
                         wr_addr[ADDR_W-1:IDX_W]};
`else
  always_comb begin
    wr_req      = 1'b0;
    wr_in_range = 1'b0;
  end

  logic unused_bits;
  assign unused_bits = ^{ctl_data_in[63:ADDR_W], rd_addr[ADDR_W-1:IDX_W],
                         CTL_WRITE_BYTE};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      addr_q       <= '0;
      last_addr    <= '0;
      last_valid   <= 1'b0;
      bus_data_out <= '0;
      bus_valid    <= 1'b0;
      pc_inhibit   <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rd_accept) begin
            addr_q     <= req_addr;
            last_addr  <= req_addr;
            last_valid <= 1'b1;
            pc_inhibit <= 1'b1;
            busy       <= 1'b1;
            err        <= (req_addr > LAST_WORD);
            cnt        <= '0;
            state      <= S_SEND;
          end else if (wr_req) begin
            // A write may change the word behind last_addr, so the next
            // read of that address must be treated as a fresh request.
            last_valid <= 1'b0;
            err        <= !wr_in_range;
          end
        end
        S_SEND: begin
          bus_data_out <= rd_byte;
          bus_valid    <= 1'b1;
          cnt          <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          bus_valid  <= 1'b0;
          pc_inhibit <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctl_fetch_responder.sv
module tb_ctl_fetch_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  op = 8'h00;
  logic [63:0] data = '0;
  logic [7:0]  bus_data_out;
  logic        bus_valid;
  logic        pc_inhibit;
  logic        busy;
  logic        err;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  int inh_len = 0;

  always #5 clk = ~clk;

  ctl_fetch_responder #(
    .CTL_READ_ADDR (8'h02),
    .CTL_WRITE_BYTE(8'h03),
    .ADDR_W        (17),
    .MEM_BYTES     (256)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ctl_op_in   (op),
    .ctl_data_in (data),
    .bus_data_out(bus_data_out),
    .bus_valid   (bus_valid),
    .pc_inhibit  (pc_inhibit),
    .busy        (busy),
    .err         (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  task automatic push4(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_q.push_back(b3);
  endtask

  task automatic wait_busy(input logic val, input string name);
    int n;
    n = 0;
    while (busy !== val && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy !== val) timeout(name);
  endtask

  task automatic wait_xfer(input string name);
    wait_busy(1'b1, {name, "_start"});
    wait_busy(1'b0, {name, "_end"});
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a byte and
  // measures the length of every pc_inhibit pulse.
  always @(negedge clk) begin
    logic [7:0] e;
    if (reset) begin
      if (bus_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_byte: got %0h expected no transfer", bus_data_out);
        end else begin
          e = exp_q.pop_front();
          chk("bus_byte", {24'h0, bus_data_out}, {24'h0, e});
        end
      end
      if (pc_inhibit) begin
        inh_len++;
      end else if (inh_len != 0) begin
        chk("inhibit_len", inh_len, 5);
        inh_len = 0;
      end
    end else begin
      inh_len = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) dut.mem[i] = 8'hEE;
    dut.mem[0]  = 8'h11; dut.mem[1]  = 8'h22; dut.mem[2]  = 8'h33; dut.mem[3]  = 8'h44;
    dut.mem[4]  = 8'h55; dut.mem[5]  = 8'h66; dut.mem[6]  = 8'h77; dut.mem[7]  = 8'h88;
    dut.mem[8]  = 8'h99; dut.mem[9]  = 8'hAA; dut.mem[10] = 8'hBB; dut.mem[11] = 8'hCC;
    dut.mem[12] = 8'hC1; dut.mem[13] = 8'hC2; dut.mem[14] = 8'hC3; dut.mem[15] = 8'hC4;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_data", {24'h0, bus_data_out}, 32'h0);
    chk("rst_valid", {31'h0, bus_valid}, 32'h0);
    chk("rst_inhibit", {31'h0, pc_inhibit}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Basic fetch of addr 0
    op = 8'h02; data = 64'h0;
    push4(8'h11, 8'h22, 8'h33, 8'h44);
    wait_xfer("t1");
    chk("t1_err", {31'h0, err}, 32'h0);

    // Same address held: no repeat; then addr 4
    repeat (10) @(negedge clk);
    chk("t2_no_repeat_busy", {31'h0, busy}, 32'h0);
    chk("t2_queue_empty", exp_q.size(), 0);
    data = 64'h4;
    push4(8'h55, 8'h66, 8'h77, 8'h88);
    wait_xfer("t2");

    // Out-of-range word
    data = 64'hFE;
    push4(8'h00, 8'h00, 8'h00, 8'h00);
    wait_xfer("t3");
    chk("t3_err_set", {31'h0, err}, 32'h1);

    // Reset during 2nd SEND cycle, then restart of addr 0
    data = 64'h0;
    exp_q.push_back(8'h11);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus_valid !== 1'b1 && n < 20);
    if (bus_valid !== 1'b1) timeout("t4_first_byte");
    chk("t4_err_clear", {31'h0, err}, 32'h0);
    #2 reset = 1'b0;
    #1;
    chk("t4_abort_data", {24'h0, bus_data_out}, 32'h0);
    chk("t4_abort_valid", {31'h0, bus_valid}, 32'h0);
    chk("t4_abort_inhibit", {31'h0, pc_inhibit}, 32'h0);
    chk("t4_abort_busy", {31'h0, busy}, 32'h0);
    chk("t4_abort_err", {31'h0, err}, 32'h0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    push4(8'h11, 8'h22, 8'h33, 8'h44);
    wait_xfer("t4_restart");

    // Unknown opcode ignored; request during SEND deferred to edge N+6
    op = 8'h05; data = 64'h40;
    repeat (8) @(negedge clk);
    chk("t5_unknown_busy", {31'h0, busy}, 32'h0);
    chk("t5_unknown_queue", exp_q.size(), 0);
    op = 8'h02; data = 64'h4;
    push4(8'h55, 8'h66, 8'h77, 8'h88);
    wait_busy(1'b1, "t5_first_start");
    @(negedge clk);
    data = 64'hC;
    push4(8'hC1, 8'hC2, 8'hC3, 8'hC4);
    wait_busy(1'b0, "t5_first_end");
    @(negedge clk);
    chk("t5_accept_n6", {31'h0, busy}, 32'h1);
    wait_busy(1'b0, "t5_second_end");

    // Byte write (only takes effect with CTL_WRITE_EN), then read addr 8
    op = 8'h03; data = (64'd8 << 8) | 64'hA5;
    repeat (2) @(negedge clk);
    chk("t6_write_busy", {31'h0, busy}, 32'h0);
    chk("t6_write_err", {31'h0, err}, 32'h0);
    op = 8'h02; data = 64'h8;
`ifdef CTL_WRITE_EN
    push4(8'hA5, 8'hAA, 8'hBB, 8'hCC);
`else
    push4(8'h99, 8'hAA, 8'hBB, 8'hCC);
`endif
    wait_xfer("t6");
    chk("t6_err", {31'h0, err}, 32'h0);

    repeat (4) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
